// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types for the HUB75 row/bit-plane scan controller.
package hub75_scan_ctrl_pkg;

  // Shift/latch sequencer states. One pass through GO..NEXT handles one bit plane of one row.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_GO    = 4'd1,
    ST_WAIT1 = 4'd2,
    ST_SWAIT = 4'd3,
    ST_TAIL  = 4'd4,
    ST_DWAIT = 4'd5,
    ST_BLANK = 4'd6,
    ST_LATCH = 4'd7,
    ST_NEXT  = 4'd8
  } scan_state_t;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation on-time timer. A load captures max(base,1) << plane and the timer
// then counts down one per cycle. o_busy is high for exactly the loaded number of cycles,
// starting the cycle after the load.
module hub75_bcm_timer #(
  parameter int LSB_W    = 8,
  parameter int N_PLANES = 8,
  parameter int PLANE_W  = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [LSB_W-1:0]   i_base,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_busy
);

  // Wide enough for the largest base shifted by the top plane, so the product never wraps.
  localparam int CNT_W = LSB_W + N_PLANES;

  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic [LSB_W-1:0] w_base;
  logic [CNT_W-1:0] w_load_val;

  // A zero base would give a zero-length display slot, so it is promoted to one cycle.
  assign w_base     = (i_base == '0) ? LSB_W'(1) : i_base;
  assign w_load_val = CNT_W'(w_base) << i_plane;

  // Down-counter with a separate busy flag so the busy output comes straight from a flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_count <= w_load_val;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/bit-plane scheduler. For every row it shifts each bit plane in turn, latches it
// into the panel and un-blanks for a binary-weighted time. The shift of the next plane runs
// while the current plane is displayed; the latch waits for the display slot to expire.
// Requires N_PLANES >= 2 and N_ROWS a power of two >= 2.
module hub75_scan_ctrl
  import hub75_scan_ctrl_pkg::*;
#(
  parameter int N_ROWS     = 32,
  parameter int N_PLANES   = 8,
  parameter int LSB_W      = 8,
  parameter int SHIFT_TAIL = 4,
  parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [LOG_N_ROWS-1:0] hub75_addr,
  output logic                  hub75_le,
  output logic                  hub75_blank,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [LOG_N_ROWS-1:0] ram_row_addr,
  output logic                  ram_buf_sel,
  input  logic                  cfg_enable,
  input  logic [LSB_W-1:0]      cfg_lsb_len,
  input  logic                  frame_swap_req,
  output logic                  frame_swap_ack,
  output logic                  frame_start
);

  localparam int PLANE_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam int TAIL_W  = $clog2(SHIFT_TAIL + 1);

  scan_state_t           r_state;
  logic [TAIL_W-1:0]     r_tail_cnt;
  logic [PLANE_W-1:0]    r_plane_idx;
  logic [N_PLANES-1:0]   r_plane_oh;
  logic [LOG_N_ROWS-1:0] r_row;
  logic [LOG_N_ROWS-1:0] r_addr;
  logic                  r_le;
  logic                  r_go;
  logic                  r_frame_start;
  logic                  r_ack;
  logic                  r_buf;

  logic w_timer_busy;
  logic w_timer_load;
  logic w_last_plane;
  logic w_last_row;

  assign w_last_plane = (r_plane_idx == PLANE_W'(N_PLANES - 1));
  assign w_last_row   = (r_row == LOG_N_ROWS'(N_ROWS - 1));
  // The timer is loaded while still pointing at the plane being latched; the advance happens in NEXT.
  assign w_timer_load = (r_state == ST_LATCH);

  hub75_bcm_timer #(
    .LSB_W    (LSB_W),
    .N_PLANES (N_PLANES),
    .PLANE_W  (PLANE_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timer_load),
    .i_base  (cfg_lsb_len),
    .i_plane (r_plane_idx),
    .o_busy  (w_timer_busy)
  );

  // Sequencer with registered outputs: each pulse is set on entry to the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tail_cnt    <= '0;
      r_plane_idx   <= '0;
      r_plane_oh    <= N_PLANES'(1);
      r_row         <= '0;
      r_addr        <= '0;
      r_le          <= 1'b0;
      r_go          <= 1'b0;
      r_frame_start <= 1'b0;
      r_ack         <= 1'b0;
      r_buf         <= 1'b0;
    end else begin
      r_le          <= 1'b0;
      r_go          <= 1'b0;
      r_frame_start <= 1'b0;
      r_ack         <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cfg_enable && shift_rdy) begin
            r_state       <= ST_GO;
            r_go          <= 1'b1;
            r_frame_start <= (r_row == '0) && (r_plane_idx == '0);
          end
        end

        // Shifter's ready flag lags shift_go, so WAIT1 keeps SWAIT from seeing a stale high.
        ST_GO:    r_state <= ST_WAIT1;
        ST_WAIT1: r_state <= ST_SWAIT;

        ST_SWAIT: begin
          if (shift_rdy) begin
            r_state    <= ST_TAIL;
            r_tail_cnt <= '0;
          end
        end

        // Lets the shifter's output pipeline drain before the data is latched.
        ST_TAIL: begin
          if (r_tail_cnt == TAIL_W'(SHIFT_TAIL - 1)) r_state <= ST_DWAIT;
          else r_tail_cnt <= r_tail_cnt + TAIL_W'(1);
        end

        // The previous plane keeps its full on-time; the latch only happens once it expires.
        ST_DWAIT: begin
          if (!w_timer_busy) r_state <= ST_BLANK;
        end

        // Row address moves together with LE so the panel never shows new data on the old row.
        ST_BLANK: begin
          r_state <= ST_LATCH;
          r_le    <= 1'b1;
          r_addr  <= r_row;
        end

        ST_LATCH: r_state <= ST_NEXT;

        ST_NEXT: begin
          r_plane_oh <= {r_plane_oh[N_PLANES-2:0], r_plane_oh[N_PLANES-1]};
          if (w_last_plane) begin
            r_plane_idx <= '0;
            r_row       <= r_row + LOG_N_ROWS'(1);
          end else begin
            r_plane_idx <= r_plane_idx + PLANE_W'(1);
          end

          if (w_last_plane && w_last_row) begin
            // Frame boundary: the only place a buffer swap or a scan stop may happen.
            if (frame_swap_req) begin
              r_buf <= ~r_buf;
              r_ack <= 1'b1;
            end
            if (cfg_enable) begin
              r_state       <= ST_GO;
              r_go          <= 1'b1;
              r_frame_start <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_GO;
            r_go    <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hub75_addr     = r_addr;
  assign hub75_le       = r_le;
  assign hub75_blank    = ~w_timer_busy;
  assign shift_plane    = r_plane_oh;
  assign shift_go       = r_go;
  assign ram_row_addr   = r_row;
  assign ram_buf_sel    = r_buf;
  assign frame_swap_ack = r_ack;
  assign frame_start    = r_frame_start;

endmodule
